drive_led3x3: RTL and testbench

Scanned driver for a 3x3 LED matrix, the output-side counterpart of the 3x3 key-matrix scanner. It accepts a 9-bit pattern plus a 9-bit blink mask over a load handshake and double-buffers them. It time-multiplexes the three rows, with a blanking gap before each row to prevent ghosting, and applies per-LED blinking on a frame-count basis. It sits between the neural-net result logic and the board LED matrix pins.

---
 rtl/drive_led3x3_if.sv | 13 +
 rtl/drive_led3x3.sv | 141 ++++++++++++++
 tb/tb_drive_led3x3.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/drive_led3x3_if.sv
// Load channel between the result logic and the 3x3 LED driver.
// load is a one-cycle strobe with no backpressure: pattern_in/blink_in are
// captured on any edge where load=1, and load_ack pulses once when the
// captured pair becomes the displayed pattern.
interface drive_led3x3_if;
   logic [8:0] pattern_in;
   logic [8:0] blink_in;
   logic       load;
   logic       load_ack;

   modport master (output pattern_in, output blink_in, output load, input load_ack);
   modport slave  (input pattern_in, input blink_in, input load, output load_ack);
endinterface

// File: rtl/drive_led3x3.sv
// Scanned 3x3 LED matrix driver: double-buffered pattern/blink mask,
// per-row blanking gap, frame-based blinking, fully registered pins.
module drive_led3x3 #(
   parameter int ROW_ON_CYCLES = 20,
   parameter int BLANK_CYCLES  = 2,
   parameter int BLINK_FRAMES  = 4
) (
   input  logic            CLOCK_50,
   input  logic            RST,
   drive_led3x3_if.slave   ctrl,
   output logic            frame_start,
   output logic [2:0]      LED_ROW_N,
   output logic [2:0]      LED_COL,
   output logic [2:0]      scan_state
);

   typedef enum logic {S_BLANK = 1'b0, S_ON = 1'b1} state_t;

   localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);
   localparam logic [7:0] ON_LAST    = 8'(ROW_ON_CYCLES - 1);
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   // Scan position describes the cycle the pins will show after the next edge.
   state_t     state, state_nx;
   logic [1:0] row, row_nx;
   logic [7:0] off, off_nx;

   logic [8:0] act_pat, act_blk, pend_pat, pend_blk;
   logic       pend, phase, first;
   logic [7:0] frame_cnt;

   logic       cycle0, on;
   logic [2:0] row_pat, row_blk, row_n_d, col_d;

   assign scan_state = {row, state};

   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         state <= S_BLANK;
         row   <= 2'd0;
         off   <= 8'd0;
      end else begin
         state <= state_nx;
         row   <= row_nx;
         off   <= off_nx;
      end
   end

   always_comb begin
      state_nx = state;
      row_nx   = row;
      off_nx   = off + 8'd1;
      if (row == 2'd3) begin
         state_nx = S_BLANK;
         row_nx   = 2'd0;
         off_nx   = 8'd0;
      end else begin
         case (state)
            S_BLANK: begin
               if (off == BLANK_LAST) begin
                  state_nx = S_ON;
                  off_nx   = 8'd0;
               end
            end
            S_ON: begin
               if (off == ON_LAST) begin
                  state_nx = S_BLANK;
                  off_nx   = 8'd0;
                  row_nx   = (row == 2'd2) ? 2'd0 : row + 2'd1;
               end
            end
            default: begin
               state_nx = S_BLANK;
               off_nx   = 8'd0;
            end
         endcase
      end
   end

   always_comb begin
      row_pat = 3'b000;
      row_blk = 3'b000;
      case (row)
         2'd0: begin row_pat = act_pat[2:0]; row_blk = act_blk[2:0]; end
         2'd1: begin row_pat = act_pat[5:3]; row_blk = act_blk[5:3]; end
         2'd2: begin row_pat = act_pat[8:6]; row_blk = act_blk[8:6]; end
         default: begin row_pat = 3'b000; row_blk = 3'b000; end
      endcase
      cycle0  = (state == S_BLANK) && (row == 2'd0) && (off == 8'd0);
      on      = (state == S_ON) && (row != 2'd3);
      row_n_d = 3'b111;
      col_d   = 3'b000;
      if (on) begin
         row_n_d = ~(3'b001 << row);
         col_d   = row_pat & ~(row_blk & {3{phase}});
      end
   end

   // The first cycle-0 after reset is not a frame end: no transfer, no blink tick.
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         LED_ROW_N     <= 3'b111;
         LED_COL       <= 3'b000;
         frame_start   <= 1'b0;
         ctrl.load_ack <= 1'b0;
         act_pat       <= 9'd0;
         act_blk       <= 9'd0;
         pend_pat      <= 9'd0;
         pend_blk      <= 9'd0;
         pend          <= 1'b0;
         phase         <= 1'b0;
         frame_cnt     <= 8'd0;
         first         <= 1'b1;
      end else begin
         first         <= 1'b0;
         LED_ROW_N     <= row_n_d;
         LED_COL       <= col_d;
         frame_start   <= cycle0;
         ctrl.load_ack <= 1'b0;
         if (cycle0 && !first) begin
            if (ctrl.load || pend) begin
               act_pat       <= ctrl.load ? ctrl.pattern_in : pend_pat;
               act_blk       <= ctrl.load ? ctrl.blink_in : pend_blk;
               ctrl.load_ack <= 1'b1;
            end
            pend <= 1'b0;
            if (frame_cnt == BLINK_LAST) begin
               frame_cnt <= 8'd0;
               phase     <= ~phase;
            end else begin
               frame_cnt <= frame_cnt + 8'd1;
            end
         end else if (ctrl.load) begin
            pend_pat <= ctrl.pattern_in;
            pend_blk <= ctrl.blink_in;
            pend     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_drive_led3x3.sv
// Directed + random bench for drive_led3x3 at default parameters (S=22, F=66);
// ack timing is scoreboarded through exp_q, pins checked against a cycle model.
module tb_drive_led3x3;
   localparam int S = 22;
   localparam int F = 66;
   localparam int BL = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_start;
   logic [2:0] row_n, col, scan_state;

   always #5 clk = ~clk;

   drive_led3x3_if bus ();

   drive_led3x3 dut (
      .CLOCK_50    (clk),
      .RST         (rst),
      .ctrl        (bus),
      .frame_start (frame_start),
      .LED_ROW_N   (row_n),
      .LED_COL     (col),
      .scan_state  (scan_state)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   int         mc = 0;
   bit         m_in_rst = 1'b1;
   logic [8:0] m_act_pat, m_act_blk, m_pend_pat, m_pend_blk;
   bit         m_pend, m_phase;
   int         m_fc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, mc, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_act_pat = '0; m_act_blk = '0; m_pend_pat = '0; m_pend_blk = '0;
      m_pend = 0; m_phase = 0; m_fc = 0;
   endtask

   task automatic tick(input bit r, input bit ld, input logic [8:0] pat, input logic [8:0] blk);
      logic [31:0] ack_at;
      int k, rr, o, idx;
      logic [2:0] e_row_n, e_col;
      bit e_ack;
      rst = r; bus.load = ld; bus.pattern_in = pat; bus.blink_in = blk;
      if (!r && ld && !m_in_rst) begin
         ack_at = 32'((mc / F + 1) * F);
         if (exp_q.size() == 0 || exp_q[$] != ack_at) exp_q.push_back(ack_at);
      end
      @(posedge clk); #1;
      if (r) begin
         m_in_rst = 1; mc = 0; model_clear(); exp_q.delete();
      end else if (m_in_rst) begin
         m_in_rst = 0; mc = 0;
      end else begin
         mc++;
         if (mc % F == 0) begin
            if (ld) begin m_act_pat = pat; m_act_blk = blk; end
            else if (m_pend) begin m_act_pat = m_pend_pat; m_act_blk = m_pend_blk; end
            m_pend = 0;
            if (m_fc == 3) begin m_fc = 0; m_phase = ~m_phase; end
            else m_fc++;
         end else if (ld) begin
            m_pend = 1; m_pend_pat = pat; m_pend_blk = blk;
         end
      end
      if (m_in_rst) begin
         check("rst_row_n", 32'(row_n), 32'h7);
         check("rst_col", 32'(col), 32'h0);
         check("rst_frame_start", 32'(frame_start), 32'h0);
         check("rst_load_ack", 32'(bus.load_ack), 32'h0);
      end else begin
         k = mc % F; rr = k / S; o = k % S;
         e_row_n = 3'b111; e_col = 3'b000;
         if (o >= BL) begin
            e_row_n[rr] = 1'b0;
            for (int c = 0; c < 3; c++) begin
               idx = 3 * rr + c;
               e_col[c] = m_act_pat[idx] & ~(m_act_blk[idx] & m_phase);
            end
         end
         e_ack = (exp_q.size() > 0) && (exp_q[0] == 32'(mc));
         check("row_n", 32'(row_n), 32'(e_row_n));
         check("col", 32'(col), 32'(e_col));
         check("frame_start", 32'(frame_start), (k == 0) ? 32'h1 : 32'h0);
         check("load_ack", 32'(bus.load_ack), 32'(e_ack));
         if (e_ack) void'(exp_q.pop_front());
      end
   endtask

   task automatic do_reset();
      tick(1, 0, '0, '0);
      tick(1, 0, '0, '0);
   endtask

   task automatic run_to(input int t);
      while (m_in_rst || mc < t) tick(0, 0, '0, '0);
   endtask

   task automatic load_now(input logic [8:0] pat, input logic [8:0] blk);
      tick(0, 1, pat, blk);
   endtask

   initial begin
      rst = 1'b1; bus.load = 1'b0; bus.pattern_in = '0; bus.blink_in = '0;
      model_clear();

      // 1: idle scan after reset
      do_reset();
      run_to(140);
      check("t1_queue_empty", 32'(exp_q.size()), 32'h0);

      // 2: single load mid-frame
      do_reset();
      run_to(10); load_now(9'h1A5, 9'h000);
      run_to(140);
      check("t2_queue_empty", 32'(exp_q.size()), 32'h0);

      // 3: two loads in one frame, last wins, single ack
      do_reset();
      run_to(5); load_now(9'h001, 9'h000);
      run_to(30); load_now(9'h100, 9'h000);
      run_to(140);
      check("t3_queue_empty", 32'(exp_q.size()), 32'h0);

      // 4: loads at F-1 and at cycle 0
      do_reset();
      run_to(65); load_now(9'h0AA, 9'h000);
      load_now(9'h155, 9'h000);
      run_to(200);
      check("t4_queue_empty", 32'(exp_q.size()), 32'h0);

      // 5: blinking over nine frames
      do_reset();
      run_to(10); load_now(9'h1FF, 9'h00F);
      run_to(9 * F + 30);
      check("t5_queue_empty", 32'(exp_q.size()), 32'h0);

      // 6: reset mid-frame with a load pending
      do_reset();
      run_to(10); load_now(9'h1FF, 9'h000);
      run_to(30);
      tick(1, 0, '0, '0);
      run_to(140);
      check("t6_queue_empty", 32'(exp_q.size()), 32'h0);

      // random loads
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0)
            tick(0, 1, 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
         else
            tick(0, 0, '0, '0);
      end
      run_to((mc / F + 1) * F + 1);
      check("rand_queue_empty", 32'(exp_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
